// File: rtl/car_drive_actuator.sv
// car_drive_actuator: drivetrain speed ramp on a prescaled tick plus a three-state door-lock actuator
module car_drive_actuator #(
    parameter int TICK_DIV   = 4,
    parameter int ACCEL_STEP = 2,
    parameter int DECEL_STEP = 3,
    parameter int MAX_SPEED  = 200,
    parameter int DOOR_DELAY = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       accelerate_car,
    input  logic       unlock_doors,
    output logic [7:0] car_speed,
    output logic       moving,
    output logic       doors_unlocked,
    output logic       tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int CW = $clog2(DOOR_DELAY + 1);
    typedef enum logic [1:0] {LOCKED = 2'd0, WAIT_ZERO = 2'd1, UNLOCKED = 2'd2} state_t;
    state_t state, state_nx;
    logic [PW-1:0] pre;
    logic [CW-1:0] zcnt, zcnt_nx;
    logic [8:0] sum;
    logic [7:0] speed_nx;
    logic accel_en;
    assign tick = pre == PW'(TICK_DIV - 1);
    assign moving = car_speed != 8'd0;
    assign doors_unlocked = state == UNLOCKED;
    assign accel_en = accelerate_car && state == LOCKED;
    assign sum = {1'b0, car_speed} + 9'(ACCEL_STEP);
    assign speed_nx = accel_en ? (sum > 9'(MAX_SPEED) ? 8'(MAX_SPEED) : sum[7:0])
                               : (car_speed > 8'(DECEL_STEP) ? car_speed - 8'(DECEL_STEP) : 8'd0);
    always_comb begin
        state_nx = LOCKED;
        zcnt_nx = zcnt;
        case (state)
            LOCKED: if (unlock_doors && !accelerate_car && car_speed == 8'd0) begin
                state_nx = WAIT_ZERO;
                zcnt_nx = '0;
            end
            WAIT_ZERO: if (unlock_doors && !accelerate_car && car_speed == 8'd0) begin
                state_nx = WAIT_ZERO;
                if (tick) begin
                    zcnt_nx = zcnt + 1'b1;
                    state_nx = zcnt_nx == CW'(DOOR_DELAY) ? UNLOCKED : WAIT_ZERO;
                end
            end
            UNLOCKED: state_nx = (!unlock_doors || accelerate_car) ? LOCKED : UNLOCKED;
            default: state_nx = LOCKED;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pre <= '0;
            car_speed <= 8'd0;
            state <= LOCKED;
            zcnt <= '0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) car_speed <= speed_nx;
            state <= state_nx;
            zcnt <= zcnt_nx;
        end
    end
endmodule

// File: tb/tb_car_drive_actuator.sv
// tb_car_drive_actuator: randomized and directed checks of car_drive_actuator against a behavioural model
module tb_car_drive_actuator;
    localparam int TD = 4, AS = 2, DS = 3, MS = 200, DD = 3;
    logic clk = 0, rst = 1, accelerate_car = 0, unlock_doors = 0;
    logic [7:0] car_speed;
    logic moving, doors_unlocked, tick;
    int errors = 0, checks = 0, dut_ticks = 0;
    int m_pre, m_speed, m_wait, m_unl;

    car_drive_actuator #(.TICK_DIV(TD), .ACCEL_STEP(AS), .DECEL_STEP(DS), .MAX_SPEED(MS), .DOOR_DELAY(DD)) dut (
        .clk(clk), .rst(rst), .accelerate_car(accelerate_car), .unlock_doors(unlock_doors),
        .car_speed(car_speed), .moving(moving), .doors_unlocked(doors_unlocked), .tick(tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pre = 0; m_speed = 0; m_wait = -1; m_unl = 0;
    endtask

    // m_wait < 0 means no unlock wait in progress; otherwise it holds zero-speed ticks seen so far
    task automatic model_edge(input bit a, input bit u, input bit r);
        bit t, locked;
        if (r) begin
            model_reset();
            return;
        end
        t = m_pre == TD - 1;
        locked = !m_unl && m_wait < 0;
        if (m_unl) m_unl = (u && !a) ? 1 : 0;
        else if (m_wait >= 0) begin
            if (!u || a || m_speed != 0) m_wait = -1;
            else if (t) begin
                m_wait++;
                if (m_wait == DD) begin m_unl = 1; m_wait = -1; end
            end
        end else if (u && !a && m_speed == 0) m_wait = 0;
        if (t) m_speed = (a && locked) ? ((m_speed + AS > MS) ? MS : m_speed + AS)
                                       : ((m_speed > DS) ? m_speed - DS : 0);
        m_pre = (m_pre + 1) % TD;
    endtask

    task automatic step(input bit a, input bit u, input bit r, input bit glitch = 0);
        accelerate_car = a; unlock_doors = u; rst = r;
        @(negedge clk);
        if (glitch) begin rst = 1; #2 rst = 0; end
        check("tick", tick, (m_pre == TD - 1) ? 1 : 0);
        check("car_speed", car_speed, m_speed);
        check("moving", moving, (m_speed != 0) ? 1 : 0);
        check("doors_unlocked", doors_unlocked, m_unl);
        if (tick) dut_ticks++;
        model_edge(a, u, r);
        @(posedge clk); #1;
    endtask

    initial begin
        bit a, u;
        @(posedge clk); #1;
        model_reset();
        step(0, 0, 1);
        dut_ticks = 0;
        repeat (40) step(1, 0, 0);
        check("ticks_in_40", dut_ticks, 10);
        step(1, 0, 0);
        check("speed_after_40", car_speed, 20);
        repeat (459) step(1, 0, 0);
        check("speed_saturated", car_speed, MS);
        step(0, 0, 1);
        repeat (40) step(1, 0, 0);
        repeat (24) step(0, 0, 0);
        check("speed_after_6_decel", car_speed, 2);
        repeat (4) step(0, 0, 0);
        check("speed_after_7_decel", car_speed, 0);
        check("moving_after_decel", moving, 0);
        repeat (16) step(0, 1, 0);
        check("unlocked_after_wait", doors_unlocked, 1);
        step(1, 1, 0);
        check("relock_on_accel", doors_unlocked, 0);
        repeat (8) step(1, 0, 0);
        repeat (10) step(0, 1, 0, 1);
        step(0, 0, 0);
        check("relock_on_drop", doors_unlocked, 0);
        a = 0; u = 0;
        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1);
            if ($urandom_range(0, 5) == 0) u = $urandom_range(0, 2) != 0;
            step(a, u, $urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
